// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl
//   Measurement sequencer for the frequency meter. It opens a gate window of
//   a selectable length and counts rising edges of an external input during
//   that window. It then latches the count with its range tag and a
//   saturation flag, and holds the reading for a display interval before
//   re-arming.
//
// Parameters
//   CLK_FREQ    clk cycles per second; base gate length (range 0)
//   CNT_W       width of the edge counter and of freq_out
//   HOLD_CYCLES cycles a reading is held before re-arm (>= 1)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   signal     asynchronous input waveform to be measured
//   run        level: 1 = measure continuously, 0 = stop after current one
//   range      gate select: N = CLK_FREQ / {1, 10, 100, 1000}
//   freq_out   raw edge count of the last completed gate
//   range_out  range used for freq_out
//   overflow   last completed gate saturated the counter
//   valid      one-cycle pulse when freq_out/range_out/overflow update
//   gate_open  high for every GATE cycle
//   busy       high in every state except IDLE
module freq_gate_ctrl #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int CNT_W       = 23,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signal,
    input  logic             run,
    input  logic [1:0]       range,
    output logic [CNT_W-1:0] freq_out,
    output logic [1:0]       range_out,
    output logic             overflow,
    output logic             valid,
    output logic             gate_open,
    output logic             busy
);

    localparam int N0 = CLK_FREQ;
    localparam int N1 = CLK_FREQ / 10;
    localparam int N2 = CLK_FREQ / 100;
    localparam int N3 = CLK_FREQ / 1000;

    // The gate down-counter only ever holds N-1 <= CLK_FREQ-1.
    localparam int GATE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    // The shortest gate must be at least one cycle and the hold non-empty.
    if (N3 < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("freq_gate_ctrl: CLK_FREQ must be >= 1000 and HOLD_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_LATCH,
        S_HOLD
    } state_t;

    state_t             state;
    logic [GATE_W-1:0]  gate_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]   edge_cnt;
    logic               ovf_acc;
    logic [1:0]         range_q;

    logic               sig_p0;
    logic               sig_p1;
    logic               sig_p2;
    logic               rise;

    // Down-counter load value (N-1) for the selected gate length.
    function automatic logic [GATE_W-1:0] gate_load(input logic [1:0] sel);
        case (sel)
            2'd0:    gate_load = GATE_W'(N0 - 1);
            2'd1:    gate_load = GATE_W'(N1 - 1);
            2'd2:    gate_load = GATE_W'(N2 - 1);
            default: gate_load = GATE_W'(N3 - 1);
        endcase
    endfunction

    // Saturating edge count step: returns {overflow, count}. A rise that
    // arrives while the counter is already full only sets the flag.
    function automatic logic [CNT_W:0] sat_count(input logic [CNT_W-1:0] cnt,
                                                 input logic             ovf);
        if (cnt == CNT_MAX)
            sat_count = {1'b1, cnt};
        else
            sat_count = {ovf, cnt + CNT_W'(1)};
    endfunction

    // ---- stage p0/p1: two-flop synchronizer; p2: edge-detect register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_p0 <= 1'b0;
            sig_p1 <= 1'b0;
            sig_p2 <= 1'b0;
        end else begin
            sig_p0 <= signal;
            sig_p1 <= sig_p0;
            sig_p2 <= sig_p1;
        end
    end

    assign rise = sig_p1 & ~sig_p2;

    // ---- sequencer: gate timing, edge counting, result latch ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            gate_cnt  <= '0;
            hold_cnt  <= '0;
            edge_cnt  <= '0;
            ovf_acc   <= 1'b0;
            range_q   <= 2'd0;
            freq_out  <= '0;
            range_out <= 2'd0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
            gate_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_ARM;
                        busy  <= 1'b1;
                    end
                end

                S_ARM: begin
                    edge_cnt  <= '0;
                    ovf_acc   <= 1'b0;
                    range_q   <= range;
                    gate_cnt  <= gate_load(range);
                    state     <= S_GATE;
                    gate_open <= 1'b1;
                end

                S_GATE: begin
                    // A rise in the final GATE cycle still lands here.
                    if (rise)
                        {ovf_acc, edge_cnt} <= sat_count(edge_cnt, ovf_acc);
                    if (gate_cnt == '0) begin
                        state     <= S_LATCH;
                        gate_open <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                    end
                end

                S_LATCH: begin
                    freq_out  <= edge_cnt;
                    range_out <= range_q;
                    overflow  <= ovf_acc;
                    valid     <= 1'b1;
                    hold_cnt  <= HOLD_LOAD;
                    state     <= S_HOLD;
                end

                S_HOLD: begin
                    // run is only looked at once the hold has expired.
                    if (hold_cnt == '0) begin
                        if (run) begin
                            state <= S_ARM;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    gate_open <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Testbench for freq_gate_ctrl (CLK_FREQ=1000, CNT_W=8, HOLD_CYCLES=5).
module tb_freq_gate_ctrl;

    localparam int CLK_FREQ    = 1000;
    localparam int CNT_W       = 8;
    localparam int HOLD_CYCLES = 5;
    localparam int HIST_LEN    = 8192;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             signal = 1'b0;
    logic             run    = 1'b0;
    logic [1:0]       range  = 2'd0;
    logic [CNT_W-1:0] freq_out;
    logic [1:0]       range_out;
    logic             overflow;
    logic             valid;
    logic             gate_open;
    logic             busy;

    freq_gate_ctrl #(
        .CLK_FREQ   (CLK_FREQ),
        .CNT_W      (CNT_W),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .signal   (signal),
        .run      (run),
        .range    (range),
        .freq_out (freq_out),
        .range_out(range_out),
        .overflow (overflow),
        .valid    (valid),
        .gate_open(gate_open),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // cyc = index of the next rising edge once the current edge has passed.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Input waveform generator. sig_hist[e] is the pin value seen at edge e.
    bit sig_hist [0:HIST_LEN-1];
    int gen_mode   = 0;   // 0 = low, 1 = periodic, 2 = single 2-cycle pulse
    int gen_period = 10;
    int gen_phase  = 0;
    int gen_se     = 0;

    initial begin
        forever begin
            bit sv;
            @(posedge clk);
            #2;
            case (gen_mode)
                1:       sv = (((cyc - gen_phase) % gen_period) < (gen_period / 2));
                2:       sv = (cyc >= gen_se) && (cyc < gen_se + 2);
                default: sv = 1'b0;
            endcase
            signal = sv;
            if (cyc < HIST_LEN) sig_hist[cyc] = sv;
        end
    end

    // Event monitors.
    int nvalid = 0;
    int gcount = 0;
    always @(negedge clk) begin
        if (valid === 1'b1)     nvalid++;
        if (gate_open === 1'b1) gcount++;
    end

    typedef struct packed {
        logic [CNT_W-1:0] f;
        logic [1:0]       r;
        logic             o;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   kk     = 0;   // edge at which the current measurement's run is sampled

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (valid === 1'b1) ok = 1'b1;
        end
    endtask

    // Rising edges the pin shows over edges [k, k+n-1].
    function automatic int count_rises(input int k, input int n);
        int c = 0;
        for (int e = k; e < k + n; e++)
            if (sig_hist[e] && !sig_hist[e-1]) c++;
        return c;
    endfunction

    task automatic push_exp(input int rises, input int r);
        exp_t e;
        e.f = (rises > 255) ? 8'd255 : CNT_W'(rises);
        e.r = 2'(r);
        e.o = (rises > 255);
        sbq.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            e = '0;
        end else begin
            e = sbq.pop_front();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (3) step();
        checks++; if (freq_out !== 8'd0)  begin errors++; $display("FAIL rst_freq: got %0d expected 0", freq_out); end
        checks++; if (range_out !== 2'd0) begin errors++; $display("FAIL rst_range: got %0d expected 0", range_out); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_ovf: got %0b expected 0", overflow); end
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL rst_valid: got %0b expected 0", valid); end
        checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL rst_gate: got %0b expected 0", gate_open); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        rst = 1'b1;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_basic();
        exp_t e; bit ok; int g0;
        gen_mode = 1; gen_period = 10; gen_phase = cyc;
        repeat (3) step();
        range = 2'd0;
        g0 = gcount;
        run = 1'b1;
        kk = cyc;
        wait_cyc(kk + CLK_FREQ);
        push_exp(100, 0);
        wait_valid(1100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no valid expected valid"); end
        checks++; if (cyc !== kk + CLK_FREQ + 3) begin errors++; $display("FAIL basic_latency: got cycle %0d expected %0d", cyc - kk, CLK_FREQ + 3); end
        checks++; if (gcount - g0 !== CLK_FREQ) begin errors++; $display("FAIL basic_gate_len: got %0d expected %0d", gcount - g0, CLK_FREQ); end
        pop_exp(e);
        checks++; if ({freq_out, range_out, overflow} !== e) begin errors++; $display("FAIL basic_result: got f=%0d r=%0d o=%0b expected f=%0d r=%0d o=%0b", freq_out, range_out, overflow, e.f, e.r, e.o); end
    endtask

    task automatic test_range();
        exp_t e; bit ok;
        range = 2'd2; gen_period = 4; gen_phase = cyc;
        kk = kk + CLK_FREQ + HOLD_CYCLES + 2;
        wait_cyc(kk + 5);
        range = 2'd3;  // mid-GATE: must not affect this measurement
        wait_cyc(kk + 10);
        push_exp(count_rises(kk, 10), 2);
        wait_valid(100, ok);
        checks++; if (!ok || cyc !== kk + 13) begin errors++; $display("FAIL range2_latency: got cycle %0d expected %0d", cyc - kk, 13); end
        pop_exp(e);
        checks++; if ({freq_out, range_out, overflow} !== e) begin errors++; $display("FAIL range2_result: got f=%0d r=%0d o=%0b expected f=%0d r=%0d o=%0b", freq_out, range_out, overflow, e.f, e.r, e.o); end
        kk = kk + 10 + HOLD_CYCLES + 2;
        wait_cyc(kk + 1);
        push_exp(count_rises(kk, 1), 3);
        wait_valid(100, ok);
        checks++; if (!ok || cyc !== kk + 4) begin errors++; $display("FAIL range3_latency: got cycle %0d expected %0d", cyc - kk, 4); end
        pop_exp(e);
        checks++; if ({freq_out, range_out, overflow} !== e) begin errors++; $display("FAIL range3_result: got f=%0d r=%0d o=%0b expected f=%0d r=%0d o=%0b", freq_out, range_out, overflow, e.f, e.r, e.o); end
    endtask

    task automatic test_overflow();
        exp_t e; bit ok;
        range = 2'd0; gen_period = 2; gen_phase = cyc;
        kk = kk + 1 + HOLD_CYCLES + 2;
        wait_cyc(kk + CLK_FREQ);
        push_exp(500, 0);
        wait_valid(1100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: got no valid expected valid"); end
        pop_exp(e);
        checks++; if ({freq_out, range_out, overflow} !== e) begin errors++; $display("FAIL ovf_result: got f=%0d r=%0d o=%0b expected f=%0d r=%0d o=%0b", freq_out, range_out, overflow, e.f, e.r, e.o); end
        gen_period = 10; gen_phase = cyc;
        kk = kk + CLK_FREQ + HOLD_CYCLES + 2;
        wait_cyc(kk + CLK_FREQ);
        push_exp(100, 0);
        wait_valid(1100, ok);
        checks++; if (!ok || cyc !== kk + CLK_FREQ + 3) begin errors++; $display("FAIL ovf_clear_latency: got cycle %0d expected %0d", cyc - kk, CLK_FREQ + 3); end
        pop_exp(e);
        checks++; if ({freq_out, range_out, overflow} !== e) begin errors++; $display("FAIL ovf_clear_result: got f=%0d r=%0d o=%0b expected f=%0d r=%0d o=%0b", freq_out, range_out, overflow, e.f, e.r, e.o); end
    endtask

    task automatic test_last_edge();
        exp_t e; bit ok;
        range = 2'd2; gen_mode = 2;
        kk = kk + CLK_FREQ + HOLD_CYCLES + 2;
        gen_se = kk + 9;      // rise seen by the counter in the last GATE cycle
        wait_cyc(kk + 10);
        push_exp(1, 2);
        wait_valid(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL last_gate_timeout: got no valid expected valid"); end
        pop_exp(e);
        checks++; if ({freq_out, range_out, overflow} !== e) begin errors++; $display("FAIL last_gate_result: got f=%0d r=%0d o=%0b expected f=%0d r=%0d o=%0b", freq_out, range_out, overflow, e.f, e.r, e.o); end
        kk = kk + 10 + HOLD_CYCLES + 2;
        gen_se = kk + 10;     // one cycle later: rise lands in LATCH
        wait_cyc(kk + 10);
        push_exp(0, 2);
        wait_valid(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL latch_edge_timeout: got no valid expected valid"); end
        pop_exp(e);
        checks++; if ({freq_out, range_out, overflow} !== e) begin errors++; $display("FAIL latch_edge_result: got f=%0d r=%0d o=%0b expected f=%0d r=%0d o=%0b", freq_out, range_out, overflow, e.f, e.r, e.o); end
    endtask

    task automatic test_run_drop();
        exp_t e; bit ok; int nv0; int c;
        gen_mode = 1; gen_period = 4; gen_phase = cyc;
        kk = kk + 10 + HOLD_CYCLES + 2;
        wait_cyc(kk + 5);
        run = 1'b0;
        wait_cyc(kk + 10);
        c = count_rises(kk, 10);
        push_exp(c, 2);
        nv0 = nvalid;
        wait_valid(100, ok);
        checks++; if (!ok || cyc !== kk + 13) begin errors++; $display("FAIL drop_latency: got cycle %0d expected %0d", cyc - kk, 13); end
        pop_exp(e);
        checks++; if ({freq_out, range_out, overflow} !== e) begin errors++; $display("FAIL drop_result: got f=%0d r=%0d o=%0b expected f=%0d r=%0d o=%0b", freq_out, range_out, overflow, e.f, e.r, e.o); end
        wait_cyc(kk + 12 + HOLD_CYCLES);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_hold_busy: got %0b expected 1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy: got %0b expected 0", busy); end
        repeat (20) step();
        checks++; if (nvalid - nv0 !== 1) begin errors++; $display("FAIL drop_valid_count: got %0d expected 1", nvalid - nv0); end
        checks++; if (freq_out !== CNT_W'(c) || busy !== 1'b0) begin errors++; $display("FAIL drop_retain: got f=%0d busy=%0b expected f=%0d busy=0", freq_out, busy, c); end
    endtask

    task automatic test_reset_mid();
        exp_t e; bit ok; int nv0;
        run = 1'b1;
        kk = cyc;
        wait_cyc(kk + 5);
        checks++; if (gate_open !== 1'b1) begin errors++; $display("FAIL mid_gate_open: got %0b expected 1", gate_open); end
        nv0 = nvalid;
        gen_mode = 0;
        rst = 1'b0;
        #1;
        checks++; if ({freq_out, range_out, overflow, valid, gate_open, busy} !== 13'd0) begin errors++; $display("FAIL mid_rst_outputs: got f=%0d r=%0d o=%0b v=%0b g=%0b b=%0b expected all 0", freq_out, range_out, overflow, valid, gate_open, busy); end
        repeat (3) step();
        rst = 1'b1;
        kk = cyc;
        gen_mode = 1; gen_phase = cyc;
        step();
        checks++; if (busy !== 1'b1 || gate_open !== 1'b0) begin errors++; $display("FAIL rearm_arm: got busy=%0b gate=%0b expected busy=1 gate=0", busy, gate_open); end
        step();
        checks++; if (gate_open !== 1'b1) begin errors++; $display("FAIL rearm_gate: got %0b expected 1", gate_open); end
        wait_cyc(kk + 10);
        push_exp(count_rises(kk, 10), 2);
        wait_valid(100, ok);
        checks++; if (!ok || cyc !== kk + 13) begin errors++; $display("FAIL rearm_latency: got cycle %0d expected %0d", cyc - kk, 13); end
        checks++; if (nvalid - nv0 !== 1) begin errors++; $display("FAIL rearm_valid_count: got %0d expected 1", nvalid - nv0); end
        pop_exp(e);
        checks++; if ({freq_out, range_out, overflow} !== e) begin errors++; $display("FAIL rearm_result: got f=%0d r=%0d o=%0b expected f=%0d r=%0d o=%0b", freq_out, range_out, overflow, e.f, e.r, e.o); end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_overflow();
        test_last_edge();
        test_run_drop();
        test_reset_mid();
        repeat (20) step();
        checks++; if (sbq.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
